amci_arbiter: RTL and testbench
===============================

AMCI_ARBITER -- requirements
Module: amci_arbiter

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin grant, 0 = fixed priority (client 0 wins).
REQ-002 Reset is resetn, synchronous, active-low; clock is clk.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: resetn  in  1  synchronous active-low reset.
REQ-005 Ports per client n in {0,1}: cn_cmd in 1 (command strobe); cn_rw in 1 (1 = write, 0 = read); cn_addr in 32; cn_wdata in 32.
REQ-006 Ports per client n: cn_busy out 1 (request accepted, not yet complete); cn_done out 1 (one-cycle completion pulse); cn_resp out 2 (AXI response); cn_rdata out 32 (read data).
REQ-007 Downstream AMCI write ports: AMCI_WADDR out 32; AMCI_WDATA out 32; AMCI_WRITE out 1; AMCI_WRESP in 2; AMCI_WIDLE in 1.
REQ-008 Downstream AMCI read ports: AMCI_RADDR out 32; AMCI_READ out 1; AMCI_RDATA in 32; AMCI_RRESP in 2; AMCI_RIDLE in 1.

Function
REQ-009 Purpose: share one AMCI port (write and read channels) between two clients, one transaction in flight at a time.
REQ-010 Accept: cn_cmd sampled when cn_busy=0; at that edge latch rw/addr/wdata into client n pending slot and set cn_busy=1.
REQ-011 cn_cmd while cn_busy=1 is ignored; the pending slot is not modified.
REQ-012 FSM states: IDLE, ISSUE, SETTLE, WAIT.
REQ-013 IDLE: if any slot pending, grant one, load AMCI_WADDR/WDATA (write) or AMCI_RADDR (read) from that slot, go to ISSUE.
REQ-014 ISSUE: AMCI_WRITE (write) or AMCI_READ (read) is 1 for exactly this one cycle; next state SETTLE.
REQ-015 SETTLE: one cycle; AMCI_WIDLE/AMCI_RIDLE ignored; next state WAIT.
REQ-016 WAIT: hold until the idle flag of the active direction is 1; on that edge capture AMCI_WRESP (write) or AMCI_RRESP plus AMCI_RDATA (read) into cn_resp/cn_rdata of the granted client, pulse cn_done for one cycle, clear cn_busy, go to IDLE.
REQ-017 Write completion leaves cn_rdata unchanged.
REQ-018 cn_resp/cn_rdata hold their value until that client's next completion.
REQ-019 Latency with arbiter idle: cmd at edge T, strobe high in cycle T+2, done no earlier than T+4.
REQ-020 RR=1 arbitration: with both slots pending in IDLE, grant the client not granted last; last-grant register resets to client 1, so client 0 wins the first tie.
REQ-021 RR=0 arbitration: client 0 always wins ties.
REQ-022 Single pending slot: granted immediately regardless of RR.
REQ-023 cn_cmd in the same cycle as cn_done is accepted (busy already 0 in that cycle).
REQ-024 Simultaneous cmds from both clients are both accepted and served back-to-back.
REQ-025 AMCI_WRITE and AMCI_READ are never 1 in the same cycle, and never 1 outside ISSUE.

Reset
REQ-026 resetn=0 at any edge: FSM to IDLE, both pending slots cleared, c0_busy=c1_busy=0, c0_done=c1_done=0, AMCI_WRITE=AMCI_READ=0, cn_resp=0, cn_rdata=0, AMCI_WADDR=AMCI_WDATA=AMCI_RADDR=0.
REQ-027 Reset during an in-flight transaction discards it: no cn_done pulse, no response capture.

Verification
REQ-028 c0 write addr 0x1000 data 0xAAAA, WIDLE low for 5 cycles after strobe -> one AMCI_WRITE pulse with WADDR=0x1000, WDATA=0xAAAA; c0_done once; c0_resp=WRESP; c0_busy low after.
REQ-029 c1 read addr 0x2000, model returns RDATA 0xDEADBEEF, RRESP 0 -> c1_rdata=0xDEADBEEF, c1_resp=0, c1_done once, AMCI_WRITE never asserted.
REQ-030 RR=1, both clients cmd in the same cycle, three rounds -> grant order 0,1,0,1,0,1; RR=0 with client 0 reissuing on each done -> client 1 starved while client 0 requests.
REQ-031 c0 cmd while c0_busy=1 with addr 0x3000 -> ignored; original address issued; exactly one done.
REQ-032 resetn low during WAIT -> all outputs at reset values next cycle, no done; a new cmd after reset completes normally.
REQ-033 Assertions over all tests: AMCI_WRITE and AMCI_READ never both high; each strobe is exactly one cycle; exactly one cn_done per accepted cmd.

Source files
------------

// File: rtl/amci_arbiter.sv
// Two-client arbiter in front of a single AMCI port (write and read channels).
// Each client has one pending slot. The shared port carries one transaction at
// a time, and a strobe is followed by a settle cycle before the idle flag of
// the active direction is trusted.
module amci_arbiter #(
  parameter bit RR = 1'b1  // 1 = round-robin on ties, 0 = client 0 always wins ties
) (
  input  logic        clk,
  input  logic        resetn,

  // client 0
  input  logic        c0_cmd,
  input  logic        c0_rw,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  output logic        c0_busy,
  output logic        c0_done,
  output logic [1:0]  c0_resp,
  output logic [31:0] c0_rdata,

  // client 1
  input  logic        c1_cmd,
  input  logic        c1_rw,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  output logic        c1_busy,
  output logic        c1_done,
  output logic [1:0]  c1_resp,
  output logic [31:0] c1_rdata,

  // downstream AMCI write channel
  output logic [31:0] AMCI_WADDR,
  output logic [31:0] AMCI_WDATA,
  output logic        AMCI_WRITE,
  input  logic [1:0]  AMCI_WRESP,
  input  logic        AMCI_WIDLE,

  // downstream AMCI read channel
  output logic [31:0] AMCI_RADDR,
  output logic        AMCI_READ,
  input  logic [31:0] AMCI_RDATA,
  input  logic [1:0]  AMCI_RRESP,
  input  logic        AMCI_RIDLE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t      state;

  // Client inputs gathered into indexable form.
  logic [1:0]  cmd;
  logic [1:0]  rw_in;
  logic [31:0] addr_in  [2];
  logic [31:0] wdata_in [2];

  // A slot is pending from acceptance until its completion; busy doubles as
  // the pending flag, since nothing else can change a slot while it is set.
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  accept;

  // Pending slot payload.
  logic [1:0]  slot_rw;
  logic [31:0] slot_addr  [2];
  logic [31:0] slot_wdata [2];

  // Per-client completion results.
  logic [1:0]  resp_q  [2];
  logic [31:0] rdata_q [2];

  // Arbitration.
  logic        grant;       // client owning the in-flight transaction
  logic        last_grant;  // client granted most recently
  logic        pick;        // client that would be granted now
  logic        act_rw;
  logic        act_idle;

  assign cmd         = {c1_cmd, c0_cmd};
  assign rw_in       = {c1_rw, c0_rw};
  assign addr_in[0]  = c0_addr;
  assign addr_in[1]  = c1_addr;
  assign wdata_in[0] = c0_wdata;
  assign wdata_in[1] = c1_wdata;

  // Commands are only taken while the client's slot is empty.
  assign accept = cmd & ~busy;

  assign c0_busy  = busy[0];
  assign c1_busy  = busy[1];
  assign c0_done  = done[0];
  assign c1_done  = done[1];
  assign c0_resp  = resp_q[0];
  assign c1_resp  = resp_q[1];
  assign c0_rdata = rdata_q[0];
  assign c1_rdata = rdata_q[1];

  // Direction and idle flag of the transaction currently on the port.
  assign act_rw   = slot_rw[grant];
  assign act_idle = act_rw ? AMCI_WIDLE : AMCI_RIDLE;

  // Choose the client to serve next from the pending slots.
  always_comb begin
    // NOTE: assign a default before any branch so that no path leaves pick
    // unassigned; otherwise the tool infers a latch.
    pick = 1'b0;
    if (busy[0] && busy[1]) begin
      pick = RR ? ~last_grant : 1'b0;
    end else if (busy[1]) begin
      pick = 1'b1;
    end
  end

  // Latch the command payload into a client's slot when it is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_rw <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          slot_rw[i]    <= rw_in[i];
          slot_addr[i]  <= addr_in[i];
          slot_wdata[i] <= wdata_in[i];
        end
      end
    end
  end

  // Transaction FSM: grant, strobe, settle, wait for idle, then report back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      busy       <= '0;
      done       <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      AMCI_WRITE <= 1'b0;
      AMCI_READ  <= 1'b0;
      AMCI_WADDR <= '0;
      AMCI_WDATA <= '0;
      AMCI_RADDR <= '0;
      for (int i = 0; i < 2; i++) begin
        resp_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      // NOTE: all state here uses non-blocking assignments, so every read in
      // this block sees the pre-edge value and later assignments to the same
      // bit (the busy clear below) simply override earlier ones.
      done       <= '0;
      AMCI_WRITE <= 1'b0;
      AMCI_READ  <= 1'b0;
      busy       <= busy | accept;

      case (state)
        S_IDLE: begin
          if (|busy) begin
            grant      <= pick;
            last_grant <= pick;
            if (slot_rw[pick]) begin
              AMCI_WADDR <= slot_addr[pick];
              AMCI_WDATA <= slot_wdata[pick];
              AMCI_WRITE <= 1'b1;
            end else begin
              AMCI_RADDR <= slot_addr[pick];
              AMCI_READ  <= 1'b1;
            end
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_SETTLE;
        end

        // The idle flags may still show the previous transaction here.
        S_SETTLE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (act_idle) begin
            done[grant] <= 1'b1;
            busy[grant] <= 1'b0;
            if (act_rw) begin
              resp_q[grant]  <= AMCI_WRESP;
            end else begin
              resp_q[grant]  <= AMCI_RRESP;
              rdata_q[grant] <= AMCI_RDATA;
            end
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// Bench for amci_arbiter. Two instances share all inputs: g_dut[0] uses
// round-robin, g_dut[1] fixed priority. A transaction-level reference model
// (pending slots, one in-flight transaction with its age in cycles) predicts
// every output each cycle; directed sequences pin the model with literal
// values, followed by a randomized run.
module tb_amci_arbiter;

  typedef struct packed {
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][1:0]  resp;
    logic [1:0][31:0] rdata;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic [31:0]      raddr;
    logic             write;
    logic             read;
  } obs_t;

  typedef struct {
    bit          pend [2];
    bit          rw   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    int          act;   // client in flight, -1 when the port is free
    int          age;   // edges since the grant edge
    int          last;  // client granted most recently
    obs_t        e;     // expected outputs
  } model_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  cmd;
  logic [1:0]  rw;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  wresp;
  logic        widle;
  logic [31:0] rdata_in;
  logic [1:0]  rresp;
  logic        ridle;

  obs_t        obs [2];
  model_t      mdl [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc  [2][2];
  int          dcnt [2][2];
  int          wcnt [2];
  logic [31:0] glog [2][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        c0_busy, c0_done, c1_busy, c1_done, amci_write, amci_read;
    logic [1:0]  c0_resp, c1_resp;
    logic [31:0] c0_rdata, c1_rdata, amci_waddr, amci_wdata, amci_raddr;

    amci_arbiter #(.RR(g == 0)) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .c0_cmd     (cmd[0]),
      .c0_rw      (rw[0]),
      .c0_addr    (addr[0]),
      .c0_wdata   (wdata[0]),
      .c0_busy    (c0_busy),
      .c0_done    (c0_done),
      .c0_resp    (c0_resp),
      .c0_rdata   (c0_rdata),
      .c1_cmd     (cmd[1]),
      .c1_rw      (rw[1]),
      .c1_addr    (addr[1]),
      .c1_wdata   (wdata[1]),
      .c1_busy    (c1_busy),
      .c1_done    (c1_done),
      .c1_resp    (c1_resp),
      .c1_rdata   (c1_rdata),
      .AMCI_WADDR (amci_waddr),
      .AMCI_WDATA (amci_wdata),
      .AMCI_WRITE (amci_write),
      .AMCI_WRESP (wresp),
      .AMCI_WIDLE (widle),
      .AMCI_RADDR (amci_raddr),
      .AMCI_READ  (amci_read),
      .AMCI_RDATA (rdata_in),
      .AMCI_RRESP (rresp),
      .AMCI_RIDLE (ridle)
    );

    assign obs[g] = obs_t'{busy: {c1_busy, c0_busy}, done: {c1_done, c0_done},
                           resp: {c1_resp, c0_resp}, rdata: {c1_rdata, c0_rdata},
                           waddr: amci_waddr, wdata: amci_wdata, raddr: amci_raddr,
                           write: amci_write, read: amci_read};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge, using the inputs present at that edge.
  function automatic model_t step(input model_t m, input bit rr);
    model_t r;
    int     g;
    r = m;
    r.e.done  = '0;
    r.e.write = 1'b0;
    r.e.read  = 1'b0;
    if (!resetn) begin
      for (int n = 0; n < 2; n++) begin
        r.pend[n] = 1'b0;
        r.rw[n]   = 1'b0;
        r.addr[n] = '0;
        r.wdat[n] = '0;
      end
      r.e    = '0;
      r.act  = -1;
      r.age  = 0;
      r.last = 1;
      return r;
    end
    if (m.act >= 0) begin
      // Idle flag is trusted only from the third edge after the grant.
      if (m.age >= 2 && (m.rw[m.act] ? widle : ridle)) begin
        r.e.done[m.act] = 1'b1;
        r.pend[m.act]   = 1'b0;
        r.act           = -1;
        if (m.rw[m.act]) begin
          r.e.resp[m.act] = wresp;
        end else begin
          r.e.resp[m.act]  = rresp;
          r.e.rdata[m.act] = rdata_in;
        end
      end else begin
        r.age = m.age + 1;
      end
    end else if (m.pend[0] || m.pend[1]) begin
      if (m.pend[0] && m.pend[1]) g = rr ? 1 - m.last : 0;
      else                        g = m.pend[0] ? 0 : 1;
      r.act  = g;
      r.age  = 0;
      r.last = g;
      if (m.rw[g]) begin
        r.e.write = 1'b1;
        r.e.waddr = m.addr[g];
        r.e.wdata = m.wdat[g];
      end else begin
        r.e.read  = 1'b1;
        r.e.raddr = m.addr[g];
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (cmd[n] && !m.pend[n]) begin
        r.pend[n] = 1'b1;
        r.rw[n]   = rw[n];
        r.addr[n] = addr[n];
        r.wdat[n] = wdata[n];
      end
    end
    r.e.busy = {r.pend[1], r.pend[0]};
    return r;
  endfunction

  // Step the model on every cycle and compare each output of both instances.
  always @(negedge clk) begin : cmp
    model_t pre;
    for (int d = 0; d < 2; d++) begin
      pre    = mdl[d];
      mdl[d] = step(mdl[d], d == 0);
      for (int n = 0; n < 2; n++) begin
        if (resetn && cmd[n] && !pre.pend[n]) acc[d][n]++;
        if (!resetn && pre.pend[n])           acc[d][n]--;
        if (obs[d].done[n])                   dcnt[d][n]++;
      end
      if (obs[d].write) begin
        wcnt[d]++;
        glog[d].push_back(obs[d].waddr);
      end
      if (obs[d].read) glog[d].push_back(obs[d].raddr);
      check($sformatf("dut%0d busy", d),  obs[d].busy,  mdl[d].e.busy);
      check($sformatf("dut%0d done", d),  obs[d].done,  mdl[d].e.done);
      check($sformatf("dut%0d resp", d),  obs[d].resp,  mdl[d].e.resp);
      check($sformatf("dut%0d rdata", d), obs[d].rdata, mdl[d].e.rdata);
      check($sformatf("dut%0d write", d), obs[d].write, mdl[d].e.write);
      check($sformatf("dut%0d read", d),  obs[d].read,  mdl[d].e.read);
      check($sformatf("dut%0d waddr", d), obs[d].waddr, mdl[d].e.waddr);
      check($sformatf("dut%0d wdata", d), obs[d].wdata, mdl[d].e.wdata);
      check($sformatf("dut%0d raddr", d), obs[d].raddr, mdl[d].e.raddr);
      check($sformatf("dut%0d strobe exclusive", d), obs[d].write & obs[d].read, 1'b0);
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input int n, input logic w, input logic [31:0] a, input logic [31:0] dat);
    cmd[n]   = 1'b1;
    rw[n]    = w;
    addr[n]  = a;
    wdata[n] = dat;
  endtask

  task automatic wait_done(input int n, input int max);
    for (int i = 0; i < max; i++) begin
      cycle();
      if (obs[0].done[n]) return;
    end
    check($sformatf("timeout waiting done c%0d", n), obs[0].done[n], 1'b1);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      cycle();
      if (obs[0].busy == 2'b00 && obs[1].busy == 2'b00) return;
    end
    check("timeout waiting idle", {obs[0].busy, obs[1].busy}, 4'h0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  task automatic check_log(input int d, input logic [31:0] exp_q [$]);
    check($sformatf("dut%0d grant count", d), glog[d].size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < glog[d].size(); i++)
      check($sformatf("dut%0d grant %0d", d, i), glog[d][i], exp_q[i]);
  endtask

  initial begin
    int          wc;
    int          dc [2];
    logic [31:0] exp_q [$];

    resetn   = 1'b0;
    cmd      = '0;
    rw       = '0;
    addr[0]  = '0;
    addr[1]  = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    wresp    = '0;
    rresp    = '0;
    rdata_in = '0;
    widle    = 1'b1;
    ridle    = 1'b1;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset busy", d),  obs[d].busy,  2'b00);
      check($sformatf("dut%0d reset done", d),  obs[d].done,  2'b00);
      check($sformatf("dut%0d reset strobes", d), {obs[d].write, obs[d].read}, 2'b00);
      check($sformatf("dut%0d reset rdata", d), obs[d].rdata, 64'h0);
      check($sformatf("dut%0d reset addr", d),  {obs[d].waddr, obs[d].raddr}, 64'h0);
    end
    resetn = 1'b1;
    cycle();

    // Client 0 write with the write channel held busy for 5 cycles.
    wresp = 2'b10;
    widle = 1'b0;
    wc    = wcnt[0];
    dc[0] = dcnt[0][0];
    set_cmd(0, 1'b1, 32'h1000, 32'hAAAA);
    cycle();
    cmd[0] = 1'b0;
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d w busy after cmd", d), obs[d].busy[0], 1'b1);
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d w strobe", d), obs[d].write, 1'b1);
      check($sformatf("dut%0d w waddr", d),  obs[d].waddr, 32'h1000);
      check($sformatf("dut%0d w wdata", d),  obs[d].wdata, 32'hAAAA);
    end
    repeat (5) cycle();
    check("w early done", obs[0].done[0], 1'b0);
    widle = 1'b1;
    wait_done(0, 10);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d w resp", d),  obs[d].resp[0],  2'b10);
      check($sformatf("dut%0d w busy", d),  obs[d].busy[0],  1'b0);
      check($sformatf("dut%0d w rdata kept", d), obs[d].rdata[0], 32'h0);
    end
    cycle();
    check("w strobe count", wcnt[0] - wc, 1);
    check("w done count", dcnt[0][0] - dc[0], 1);

    // Client 1 read with the arbiter idle: exact latency.
    wc       = wcnt[0];
    rdata_in = 32'hDEADBEEF;
    rresp    = 2'b00;
    set_cmd(1, 1'b0, 32'h2000, 32'h0);
    cycle();
    cmd[1] = 1'b0;
    cycle();
    check("r strobe", obs[0].read, 1'b1);
    check("r raddr", obs[0].raddr, 32'h2000);
    cycle();
    cycle();
    check("r not done before T+4", obs[0].done[1], 1'b0);
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d r done", d),  obs[d].done[1],  1'b1);
      check($sformatf("dut%0d r rdata", d), obs[d].rdata[1], 32'hDEADBEEF);
      check($sformatf("dut%0d r resp", d),  obs[d].resp[1],  2'b00);
    end
    check("r no write strobe", wcnt[0] - wc, 0);

    // Command while busy is ignored; command during the done cycle is taken.
    dc[0] = dcnt[0][0];
    set_cmd(0, 1'b1, 32'h4000, 32'h1111);
    cycle();
    set_cmd(0, 1'b1, 32'h3000, 32'h2222);
    cycle();
    check("ignored cmd waddr", obs[0].waddr, 32'h4000);
    check("ignored cmd wdata", obs[0].wdata, 32'h1111);
    cmd[0] = 1'b0;
    wait_done(0, 10);
    set_cmd(0, 1'b0, 32'h5000, 32'h0);
    cycle();
    cmd[0] = 1'b0;
    check("cmd in done cycle busy", obs[0].busy[0], 1'b1);
    cycle();
    check("cmd in done cycle raddr", obs[0].raddr, 32'h5000);
    wait_done(0, 10);
    cycle();
    check("one done per accepted cmd", dcnt[0][0] - dc[0], 2);

    // Reset in WAIT discards the transaction.
    widle = 1'b0;
    set_cmd(1, 1'b1, 32'h6000, 32'h6666);
    cycle();
    cmd[1] = 1'b0;
    repeat (6) cycle();
    dc[1] = dcnt[0][1];
    pulse_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d rst busy", d),  obs[d].busy,  2'b00);
      check($sformatf("dut%0d rst rdata", d), obs[d].rdata, 64'h0);
      check($sformatf("dut%0d rst resp", d),  obs[d].resp,  4'h0);
      check($sformatf("dut%0d rst waddr", d), obs[d].waddr, 32'h0);
    end
    widle = 1'b1;
    repeat (3) cycle();
    check("no done after reset", dcnt[0][1] - dc[1], 0);
    wresp = 2'b01;
    set_cmd(1, 1'b1, 32'h7000, 32'h7777);
    cycle();
    cmd[1] = 1'b0;
    wait_done(1, 10);
    check("post-reset resp", obs[0].resp[1], 2'b01);

    // Three rounds of simultaneous commands from a fresh reset.
    pulse_reset();
    glog[0].delete();
    glog[1].delete();
    for (int r = 0; r < 3; r++) begin
      set_cmd(0, 1'b1, 32'h100 + r, 32'h0);
      set_cmd(1, 1'b0, 32'h200 + r, 32'h0);
      cycle();
      cmd = '0;
      wait_idle(30);
    end
    exp_q = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
    check_log(0, exp_q);
    check_log(1, exp_q);

    // Tie after client 0 was served last: the two policies diverge.
    glog[0].delete();
    glog[1].delete();
    set_cmd(0, 1'b1, 32'h300, 32'h0);
    cycle();
    cmd = '0;
    wait_idle(30);
    set_cmd(0, 1'b1, 32'h301, 32'h0);
    set_cmd(1, 1'b1, 32'h401, 32'h0);
    cycle();
    cmd = '0;
    wait_idle(30);
    exp_q = '{32'h300, 32'h401, 32'h301};
    check_log(0, exp_q);
    exp_q = '{32'h300, 32'h301, 32'h401};
    check_log(1, exp_q);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      resetn   = ($urandom_range(0, 399) != 0);
      for (int n = 0; n < 2; n++) begin
        cmd[n]   = ($urandom_range(0, 2) == 0);
        rw[n]    = $urandom_range(0, 1);
        addr[n]  = $urandom;
        wdata[n] = $urandom;
      end
      widle    = ($urandom_range(0, 3) == 0);
      ridle    = ($urandom_range(0, 2) == 0);
      wresp    = $urandom_range(0, 3);
      rresp    = $urandom_range(0, 3);
      rdata_in = $urandom;
      cycle();
    end

    resetn = 1'b1;
    cmd    = '0;
    widle  = 1'b1;
    ridle  = 1'b1;
    wait_idle(50);
    cycle();
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 2; n++)
        check($sformatf("dut%0d c%0d done vs accepted", d, n), dcnt[d][n], acc[d][n]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
